weight_chain_load_seq: RTL and testbench
========================================

Name: weight_chain_load_seq

Overview:
- Sequences a chain of `register_sync_with_enable` stages: a shift chain plus a shadow (commit) bank. Used for weight/bias loading into PE columns.
- Accepts up to NUM_STAGES words from a valid/ready stream and drives the shared shift enable.
- Zero-pads any unfilled stages, then pulses the commit enable so the shadow bank updates atomically.
- Controller only: the datapath registers and muxes live outside this block.

Parameters:
- NUM_STAGES, 8, number of registers in the shift chain; must be >= 2.
- CNT_W, $clog2(NUM_STAGES+1), width of the word count and internal counter; derived, do not override.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a load sequence; sampled only in IDLE
- num_words  input  CNT_W  words to take from the stream; sampled with start
- abort  input  1  cancel the sequence in progress without committing
- in_valid  input  1  upstream word valid
- in_ready  output  1  block accepts a word this cycle
- shift_en  output  1  enable for every shift-chain register (advance one stage)
- zero_fill  output  1  selects 0 instead of stream data into chain stage 0
- commit_en  output  1  enable for every shadow register (copy chain to shadow bank)
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse when the commit happens

Behaviour:
- States: IDLE, LOAD, PAD, COMMIT. State register `cnt` is CNT_W bits; `target` is latched.
- Reset: state=IDLE, cnt=0, target=0. In IDLE every output is 0.
- IDLE with start=1:
  - target = min(num_words, NUM_STAGES); cnt=0.
  - target==0 → next state PAD; otherwise next state LOAD.
- IDLE with start=0: stay in IDLE.
- start while busy=1 is ignored.
- LOAD:
  - in_ready=1; shift_en = in_valid; zero_fill=0.
  - On each handshake (in_valid & in_ready): cnt++.
  - On the handshake that makes cnt==target: next state PAD if target<NUM_STAGES, else COMMIT.
  - With in_valid=0: hold, no shift.
- PAD:
  - shift_en=1, zero_fill=1, in_ready=0, cnt++ every cycle.
  - When cnt reaches NUM_STAGES: next state COMMIT.
  - PAD lasts NUM_STAGES-target cycles.
- COMMIT: commit_en=1 and done=1 for exactly one cycle; shift_en=0, in_ready=0; next state IDLE.
- busy = (state != IDLE).
- Output timing:
  - shift_en, in_ready, zero_fill, commit_en and done are combinational decodes of state and in_valid only.
  - No combinational path from start or num_words to any output.
- Total shift_en pulses per sequence = NUM_STAGES exactly. Word k (0-based) ends in stage NUM_STAGES-1-k relative to padding, so the first word reaches the far end.
- abort in LOAD or PAD:
  - Next state IDLE, no commit_en, no done.
  - The shift in the abort cycle still occurs if shift_en=1 (outputs are not gated by abort).
  - abort in IDLE or COMMIT is ignored.
- abort and start in the same IDLE cycle: start wins, because abort is ignored in IDLE.
- Reset mid-sequence: back to IDLE next cycle; no commit. Shadow bank contents are untouched by this block.
- Counter never exceeds NUM_STAGES, so there is no wrap-around.

Test Plan:
- NUM_STAGES=8, num_words=8, in_valid held high:
  - in_ready high for 8 cycles, 8 shift_en pulses, zero_fill never high.
  - commit_en and done on cycle 9 after start+1; busy low on the following cycle.
- num_words=3 with continuous valid:
  - 3 shifts with zero_fill=0, then 5 shifts with zero_fill=1.
  - One commit; 8 shift_en pulses in total.
- num_words=0:
  - No in_ready at all; 8 PAD shifts with zero_fill=1, then commit (clears weights).
- num_words=12:
  - Clamped to 8: exactly 8 handshakes, then a 9th valid word is not accepted (in_ready=0 in COMMIT).
- Stalls: num_words=4, in_valid pattern 1,0,0,1,1,0,1:
  - shift_en follows the valid pattern; cnt holds during gaps.
  - PAD starts the cycle after the 4th handshake.
- Abort and reset:
  - abort at cnt=2 in LOAD → IDLE, commit_en and done never pulse; a new start then runs a full 8-shift sequence.
  - reset asserted in PAD → all outputs 0 the next cycle.

Source files
------------

// File: rtl/weight_chain_load_seq.sv
// Load sequencer for a weight/bias shift chain with a shadow commit bank.
// Takes up to NUM_STAGES stream words, zero-pads the remaining stages, then commits.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start; every output low
//   LOAD   | accepting stream words, one shift per handshake
//   PAD    | shifting zeros into stage 0 until NUM_STAGES shifts are done
//   COMMIT | one-cycle copy of the chain into the shadow bank
module weight_chain_load_seq #(
  parameter int NUM_STAGES = 8,
  parameter int CNT_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic             zero_fill,
  output logic             commit_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, PAD, COMMIT} state_t;

  localparam logic [CNT_W-1:0] STAGES = CNT_W'(NUM_STAGES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] start_target;

  assign cnt_inc      = cnt + 1'b1;
  assign start_target = (num_words > STAGES) ? STAGES : num_words;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            target <= start_target;
            cnt    <= '0;
            state  <= (start_target == '0) ? PAD : LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else if (in_valid) begin
            cnt <= cnt_inc;
            if (cnt_inc == target)
              state <= (target < STAGES) ? PAD : COMMIT;
          end
        end
        PAD: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == STAGES)
              state <= COMMIT;
          end
        end
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pure decodes of state (and in_valid for the LOAD shift); start/num_words never reach outputs.
  assign in_ready  = (state == LOAD);
  assign shift_en  = ((state == LOAD) && in_valid) || (state == PAD);
  assign zero_fill = (state == PAD);
  assign commit_en = (state == COMMIT);
  assign done      = (state == COMMIT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_weight_chain_load_seq.sv
// Directed bench for weight_chain_load_seq: per-cycle expected output vectors are
// queued by the stimulus and popped/compared by an independent monitor.
module tb_weight_chain_load_seq;

  localparam int N = 8;
  localparam int W = $clog2(N + 1);

  // Expected vector bit order: {busy, in_ready, shift_en, zero_fill, commit_en, done}
  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_LDV  = 6'b111000;
  localparam logic [5:0] O_LDN  = 6'b110000;
  localparam logic [5:0] O_PAD  = 6'b101100;
  localparam logic [5:0] O_CMT  = 6'b100011;

  typedef struct {
    logic [5:0] exp;
    int         tst;
    int         cyc;
  } item_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] num_words = '0;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready, shift_en, zero_fill, commit_en, busy, done;

  item_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cur_tst = 0;
  int    cur_cyc = 0;

  weight_chain_load_seq #(.NUM_STAGES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_words (num_words),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .shift_en  (shift_en),
    .zero_fill (zero_fill),
    .commit_en (commit_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Monitor: compares DUT outputs against the oldest queued expectation each cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      item_t it;
      logic [5:0] act;
      it  = exp_q.pop_front();
      act = {busy, in_ready, shift_en, zero_fill, commit_en, done};
      n_checks++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL outputs test%0d cycle%0d: got busy/rdy/shf/zf/cmt/done=%b expected %b",
                 it.tst, it.cyc, act, it.exp);
      end
    end
  end

  task automatic cyc(input logic s, input int nw, input logic ab, input logic v,
                     input logic rs, input logic [5:0] e);
    item_t it;
    @(posedge clk);
    #1;
    start     = s;
    num_words = W'(nw);
    abort     = ab;
    in_valid  = v;
    reset     = rs;
    it.exp = e;
    it.tst = cur_tst;
    it.cyc = cur_cyc;
    exp_q.push_back(it);
    cur_cyc++;
  endtask

  task automatic begin_test(input int t);
    cur_tst = t;
    cur_cyc = 0;
  endtask

  // Full load with valid held high (num_words=8, or 12 which clamps to 8).
  task automatic full_load(input int nw, input logic ab0);
    cyc(1, nw, ab0, 1, 0, O_IDLE);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0, O_LDV);
    cyc(0, 0, 0, 1, 0, O_CMT);   // 9th valid word not accepted
    cyc(0, 0, 0, 1, 0, O_IDLE);
    cyc(0, 0, 0, 0, 0, O_IDLE);
  endtask

  initial begin
    #10000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    @(posedge clk);
    begin_test(0);
    cyc(0, 0, 0, 0, 1, O_IDLE);
    cyc(0, 0, 0, 1, 0, O_IDLE);
    cyc(0, 0, 0, 1, 0, O_IDLE);

    begin_test(1);
    full_load(8, 0);

    // 3 words, 5 pad shifts; a start during PAD must be ignored
    begin_test(2);
    cyc(1, 3, 0, 1, 0, O_IDLE);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, O_LDV);
    cyc(0, 0, 0, 1, 0, O_PAD);
    cyc(1, 0, 0, 1, 0, O_PAD);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, O_PAD);
    cyc(0, 0, 0, 1, 0, O_CMT);
    cyc(0, 0, 0, 0, 0, O_IDLE);

    // zero words: pure padding; abort in COMMIT ignored
    begin_test(3);
    cyc(1, 0, 0, 0, 0, O_IDLE);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, O_PAD);
    cyc(0, 0, 1, 0, 0, O_CMT);
    cyc(0, 0, 0, 0, 0, O_IDLE);

    begin_test(4);
    full_load(12, 0);

    // stalls: valid 1,0,0,1,1,0,1 with num_words=4
    begin_test(5);
    cyc(1, 4, 0, 0, 0, O_IDLE);
    cyc(0, 0, 0, 1, 0, O_LDV);
    cyc(0, 0, 0, 0, 0, O_LDN);
    cyc(0, 0, 0, 0, 0, O_LDN);
    cyc(0, 0, 0, 1, 0, O_LDV);
    cyc(0, 0, 0, 1, 0, O_LDV);
    cyc(0, 0, 0, 0, 0, O_LDN);
    cyc(0, 0, 0, 1, 0, O_LDV);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, O_PAD);
    cyc(0, 0, 0, 0, 0, O_CMT);
    cyc(0, 0, 0, 0, 0, O_IDLE);

    // abort at cnt=2 in LOAD: the abort-cycle shift happens, no commit
    begin_test(6);
    cyc(1, 8, 0, 1, 0, O_IDLE);
    cyc(0, 0, 0, 1, 0, O_LDV);
    cyc(0, 0, 0, 1, 0, O_LDV);
    cyc(0, 0, 1, 1, 0, O_LDV);
    cyc(0, 0, 0, 1, 0, O_IDLE);
    cyc(0, 0, 0, 0, 0, O_IDLE);

    // start together with abort in IDLE: start wins, full sequence runs
    begin_test(7);
    full_load(8, 1);

    // abort in PAD
    begin_test(8);
    cyc(1, 6, 0, 1, 0, O_IDLE);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, O_LDV);
    cyc(0, 0, 1, 0, 0, O_PAD);
    cyc(0, 0, 0, 0, 0, O_IDLE);
    cyc(0, 0, 0, 0, 0, O_IDLE);

    // reset during PAD: outputs clear the next cycle
    begin_test(9);
    cyc(1, 0, 0, 0, 0, O_IDLE);
    cyc(0, 0, 0, 0, 0, O_PAD);
    cyc(0, 0, 0, 0, 1, O_PAD);
    cyc(0, 0, 0, 0, 0, O_IDLE);
    cyc(0, 0, 0, 0, 0, O_IDLE);

    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
